// File: rtl/ahb_pkg.sv
// Shared AHB-lite encodings and the DMA master FSM state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DATA    = 4'b0011;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_ADDR = 3'd3,
    ST_WR_DATA = 3'd4
  } state_t;

endpackage

// File: rtl/ahblite_dma_master.sv
// Single-channel AHB-lite DMA master: copies len words from src to dst using non-pipelined
// SINGLE word transfers. Defining AHBLITE_DMA_IRQ_EN adds the irq/irq_clr interrupt pair.
module ahblite_dma_master
  import ahb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] src_addr,
  input  logic [31:0] dst_addr,
  input  logic [15:0] len,
  input  logic        dst_inc,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP,
`ifdef AHBLITE_DMA_IRQ_EN
  output logic        irq,
  input  logic        irq_clr,
`endif
  output state_t      o_dbg_state
);

  state_t      r_state;
  logic [31:0] r_src;
  logic [31:0] r_dst;
  logic [31:0] r_hold;
  logic [31:0] r_haddr;
  logic [31:0] r_hwdata;
  logic [15:0] r_count;
  logic [1:0]  r_htrans;
  logic        r_inc;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic        r_hwrite;
  logic [31:0] w_src_next;
  logic [31:0] w_dst_next;

  // Address arithmetic wraps naturally at 2^32.
  assign w_src_next = r_src + 32'd4;
  assign w_dst_next = r_inc ? (r_dst + 32'd4) : r_dst;

  // Handshake: start is accepted only in IDLE; busy covers the whole copy and done pulses once
  // on clean completion. On the bus, an address or data phase completes on a cycle with HREADY=1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_src    <= '0;
      r_dst    <= '0;
      r_hold   <= '0;
      r_haddr  <= '0;
      r_hwdata <= '0;
      r_count  <= '0;
      r_htrans <= HTRANS_IDLE;
      r_inc    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_hwrite <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (len != 16'd0) begin
              r_src    <= src_addr;
              r_dst    <= dst_addr;
              r_count  <= len;
              r_inc    <= dst_inc;
              r_err    <= 1'b0;
              r_busy   <= 1'b1;
              r_state  <= ST_RD_ADDR;
              r_htrans <= HTRANS_NONSEQ;
              r_haddr  <= src_addr;
              r_hwrite <= 1'b0;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        ST_RD_ADDR: begin
          if (HREADY) begin
            r_state  <= ST_RD_DATA;
            r_htrans <= HTRANS_IDLE;
          end
        end
        ST_RD_DATA: begin
          if (HRESP) begin
            r_state  <= ST_IDLE;
            r_err    <= 1'b1;
            r_busy   <= 1'b0;
            r_htrans <= HTRANS_IDLE;
            r_hwrite <= 1'b0;
          end else if (HREADY) begin
            r_hold   <= HRDATA;
            r_state  <= ST_WR_ADDR;
            r_htrans <= HTRANS_NONSEQ;
            r_haddr  <= r_dst;
            r_hwrite <= 1'b1;
          end
        end
        ST_WR_ADDR: begin
          if (HREADY) begin
            r_state  <= ST_WR_DATA;
            r_htrans <= HTRANS_IDLE;
            r_hwdata <= r_hold;
          end
        end
        ST_WR_DATA: begin
          if (HRESP) begin
            r_state  <= ST_IDLE;
            r_err    <= 1'b1;
            r_busy   <= 1'b0;
            r_htrans <= HTRANS_IDLE;
            r_hwrite <= 1'b0;
          end else if (HREADY) begin
            r_count  <= r_count - 16'd1;
            r_src    <= w_src_next;
            r_dst    <= w_dst_next;
            r_hwrite <= 1'b0;
            if (r_count == 16'd1) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state  <= ST_RD_ADDR;
              r_htrans <= HTRANS_NONSEQ;
              r_haddr  <= w_src_next;
            end
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_busy   <= 1'b0;
          r_htrans <= HTRANS_IDLE;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;
  assign HADDR       = r_haddr;
  assign HTRANS      = r_htrans;
  assign HWRITE      = r_hwrite;
  assign HWDATA      = r_hwdata;
  assign HSIZE       = HSIZE_WORD;
  assign HBURST      = HBURST_SINGLE;
  assign HPROT       = HPROT_DATA;
  assign HMASTLOCK   = 1'b0;
  assign o_dbg_state = r_state;

`ifdef AHBLITE_DMA_IRQ_EN
  logic r_irq;
  logic r_err_d;

  // Clear has priority over a same-cycle set source.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq   <= 1'b0;
      r_err_d <= 1'b0;
    end else begin
      r_err_d <= r_err;
      if (irq_clr) begin
        r_irq <= 1'b0;
      end else if (r_done || (r_err && !r_err_d)) begin
        r_irq <= 1'b1;
      end
    end
  end

  assign irq = r_irq;
`endif

endmodule

// File: doc/ahblite_dma_master.md
AHBLITE_DMA_MASTER -- requirements
Module: ahblite_dma_master

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 SHALL have port `clk`, input, 1 bit: system/AHB clock; all logic on rising edge.
REQ-003 SHALL have port `rst`, input, 1 bit: synchronous active-high reset.
REQ-004 SHALL have port `start`, input, 1 bit: one-cycle pulse that launches a transfer.
REQ-005 SHALL have port `src_addr`, input, 32 bits: word-aligned source base address.
REQ-006 SHALL have port `dst_addr`, input, 32 bits: word-aligned destination base address.
REQ-007 SHALL have port `len`, input, 16 bits: number of words to move.
REQ-008 SHALL have port `dst_inc`, input, 1 bit: 1 = increment destination; 0 = fixed destination (LCD data register).
REQ-009 SHALL have port `busy`, output, 1 bit: transfer in progress.
REQ-010 SHALL have port `done`, output, 1 bit: one-cycle pulse on successful completion.
REQ-011 SHALL have port `err`, output, 1 bit: sticky flag, set on HRESP error.
REQ-012 SHALL have AHB-lite master outputs: HADDR 32 bits, HTRANS 2 bits, HSIZE 3 bits, HBURST 3 bits, HPROT 4 bits, HMASTLOCK 1 bit, HWRITE 1 bit, HWDATA 32 bits.
REQ-013 SHALL have AHB-lite master inputs: HRDATA 32 bits, HREADY 1 bit, HRESP 1 bit.

Function
REQ-014 SHALL drive fixed bus fields at all times: HSIZE=3'b010, HBURST=3'b000 (SINGLE), HPROT=4'b0011, HMASTLOCK=0.
REQ-015 SHALL implement FSM states IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA; transfers are non-pipelined single transfers.
REQ-016 SHALL, in IDLE on start=1 with len!=0, latch src_addr/dst_addr/len/dst_inc, clear err, set busy, and enter RD_ADDR on the next edge.
REQ-017 SHALL, on start with len==0, pulse done one cycle later, never assert busy, and issue no bus transfer.
REQ-018 SHALL, in RD_ADDR, drive HTRANS=NONSEQ, HADDR=current src, HWRITE=0; advance to RD_DATA when HREADY=1, else hold.
REQ-019 SHALL, in RD_DATA, drive HTRANS=IDLE; capture HRDATA into a 32-bit holding register when HREADY=1 and enter WR_ADDR.
REQ-020 SHALL, in WR_ADDR, drive HTRANS=NONSEQ, HADDR=current dst, HWRITE=1; advance to WR_DATA when HREADY=1.
REQ-021 SHALL, in WR_DATA, drive HTRANS=IDLE and HWDATA=holding register, stable until HREADY=1.
REQ-022 SHALL, on WR_DATA completion, decrement the remaining-word count, add 4 to src, and add 4 to dst only when dst_inc=1.
REQ-023 SHALL treat address arithmetic as modulo 2^32, so 0xFFFFFFFC+4 = 0x00000000.
REQ-024 SHALL, after WR_DATA completion, return to RD_ADDR if the count is nonzero; if zero, enter IDLE, drop busy and pulse done in that same cycle.
REQ-025 SHALL reach minimum throughput of 4 cycles per word when HREADY is constantly high.
REQ-026 SHALL, on HRESP=1 in any data phase, set err, drop busy, enter IDLE with HTRANS=IDLE, and not pulse done.
REQ-027 SHALL ignore start while busy.

Reset
REQ-028 SHALL set, on rst=1: state=IDLE, busy=0, done=0, err=0, HTRANS=IDLE, HWRITE=0, HADDR=0, HWDATA=0, count=0.
REQ-029 SHALL, when rst is asserted mid-transfer, abort the transfer and drive HTRANS=IDLE from the next edge.

Configuration
REQ-030 SHALL, with AHBLITE_DMA_IRQ_EN defined, add ports `irq` (output, 1 bit) and `irq_clr` (input, 1 bit).
REQ-031 SHALL, with AHBLITE_DMA_IRQ_EN defined, set irq on done or on err rising, and clear it on irq_clr; irq_clr wins on a same-cycle collision.
REQ-032 SHALL, without AHBLITE_DMA_IRQ_EN, have neither port nor irq logic; the caller polls busy/err.

Structure
REQ-033 SHALL place HTRANS encodings (IDLE=2'b00, NONSEQ=2'b10), the HSIZE word constant and the FSM state encoding in a shared package, ahb_pkg.
REQ-034 SHALL be a single module with no sub-module; address/count registers live inline.

Verification
REQ-035 SHALL cover: len=3, src=0x20000000, dst=0x40000000, dst_inc=1, HREADY=1 -> 6 transfers, 3 words copied, done at cycle 13 after start, busy for 12 cycles.
REQ-036 SHALL cover: len=4, dst=0x40000010, dst_inc=0 -> all 4 writes to 0x40000010 in source order.
REQ-037 SHALL cover: HREADY low 3 cycles in each RD_DATA, len=2 -> HADDR/HWDATA held stable, data correct, done at cycle 15.
REQ-038 SHALL cover: HRESP=1 on the second read data phase -> err=1, busy=0, no done, no further NONSEQ.
REQ-039 SHALL cover: start with len=0 -> done one cycle later, HTRANS stays IDLE; a start pulse while busy is ignored.
REQ-040 SHALL cover: rst asserted during WR_ADDR -> next cycle HTRANS=IDLE, busy=0, all outputs at reset values; src=0xFFFFFFFC, len=2 wraps to 0x00000000.
